chacha_round_ctrl: RTL and testbench
====================================

# chacha_round_ctrl

Sequencer for the 2-round ChaCha datapath (`plus_xor`) in the encrypt path. It accepts a key/nonce/counter command and builds the 16-word ChaCha input state. It then iterates that state through the external double-round datapath `DOUBLE_ROUNDS` times, applies the feed-forward addition, and streams the 64-byte keystream block as 32-bit words with backpressure. A multi-block command auto-increments the block counter.

## Interface
Parameters:
- `PRO_INTERVAL`, 8: nominal datapath latency, `dp_req` to `dp_done`, in cycles.
- `DOUBLE_ROUNDS`, 10: double-round iterations per block; 10 gives ChaCha20. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_key`  in  256  key; `cmd_key[32i+31:32i]` is key word i.
- `cmd_nonce`  in  96  nonce; `cmd_nonce[32j+31:32j]` is nonce word j.
- `cmd_ctr`  in  32  initial block counter.
- `cmd_nblk`  in  8  number of blocks; 0 means 256.
- `dp_req`  out  1  one-cycle start pulse to the datapath.
- `dp_state_o`  out  512  datapath input state; word n at `[32n+31:32n]`.
- `dp_state_i`  in  512  datapath result, same packing.
- `dp_done`  in  1  datapath finish pulse.
- `ks_valid`  out  1  keystream word valid.
- `ks_ready`  in  1  downstream accept.
- `ks_data`  out  32  keystream word.
- `ks_last_word`  out  1  marks word 15 of a block.
- `ks_last_blk`  out  1  marks the final block of the command.
- `err`  out  1  datapath timeout pulse; only with `CHACHA_DP_TIMEOUT_EN`.

## Operation
- States: IDLE → ISSUE → WAIT → (ISSUE | ADD) → OUT → (ISSUE | IDLE).
- **IDLE:** `cmd_ready`=1. On `cmd_valid&&cmd_ready`, latch the command and build the initial state S0:
  - words 0–3: 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - words 4–11: key words 0–7.
  - word 12: ctr.
  - words 13–15: nonce words 0–2.
  - Set the working state W=S0 and the iteration count it=0. Go to ISSUE.
- **ISSUE:** `dp_req`=1 for one cycle. `dp_state_o`=W, held stable until `dp_done` is captured. Go to WAIT.
- **WAIT:** on `dp_done`, capture W←`dp_state_i` and increment it.
  - If it==`DOUBLE_ROUNDS`, go to ADD; otherwise go to ISSUE.
  - `dp_done` in any other state is ignored.
- **ADD:** for each n, O[n] = W[n] + S0[n] mod 2^32, registered. Word index widx=0. Go to OUT.
- **OUT:** `ks_valid`=1, `ks_data`=O[widx]. `ks_last_word`=(widx==15). `ks_last_blk`=(remaining blocks==1).
  - On `ks_valid&&ks_ready`, widx advances.
  - When widx=15 is accepted with blocks remaining: decrement the remaining count and set S0[12]=S0[12]+1 (wraps 0xFFFFFFFF→0, no flag). Reset W=S0 and it=0, then go to ISSUE.
  - When widx=15 is accepted on the last block, go to IDLE.
- **Reset:** `rst` is honoured in any state and at any time; the block returns to IDLE and the in-flight command is dropped. The datapath is not flushed, and a late `dp_done` is ignored because the block is in IDLE.
- **Reset values:** `cmd_ready`=0 while `rst` is high, then 1. All other outputs are 0: `dp_req`, `dp_state_o`, `ks_valid`, `ks_data`, `ks_last_word`, `ks_last_blk`, `err`.

## Timing
- Cycle 0 is the command handshake; `dp_req` fires at cycle 1.
- With the datapath returning `dp_done` exactly P=`PRO_INTERVAL` cycles after `dp_req`, each double round costs P+1 cycles.
- Final `dp_done` arrives at cycle D(P+1), where D=`DOUBLE_ROUNDS`. ADD follows at D(P+1)+1, and the first `ks_valid` at D(P+1)+2. With defaults that is cycle 92.
- Under continuous `ks_ready`, the 16 words occupy 16 consecutive cycles.
- The next block's `dp_req` fires in the cycle after word 15 is accepted.
- `cmd_ready` rises in the cycle after the final word is accepted.
- `ks_data` and the `ks_last_*` flags are stable while `ks_valid && !ks_ready`.
- `dp_done` is only accepted in WAIT. If `dp_done` arrives in the same cycle as `dp_req`, it is ignored.

## Configuration
- Macro: `CHACHA_DP_TIMEOUT_EN`.
- Defined:
  - A watchdog counts cycles in WAIT.
  - If 2·`PRO_INTERVAL` cycles elapse without `dp_done`, `err` pulses for 1 cycle and the block returns to IDLE, dropping the command with no keystream output for the current block.
- Undefined:
  - No watchdog; WAIT is held indefinitely.
  - `err` is tied to 0.

## Test plan
- **RFC 7539 §2.3.2 vector:** key 00..1f, nonce 000000090000004a00000000, ctr=1, nblk=1, behavioural datapath with P=8 → `ks_valid` first at cycle 92; words 0 and 15 = 0xe4e7f110 and 0x4e3c50a2; `ks_last_word` and `ks_last_blk` high on word 15.
- **Multi-block with counter wrap:** nblk=3, ctr=0xFFFFFFFE → blocks use ctr FFFFFFFE, FFFFFFFF, 00000000; `ks_last_blk` high only during block 3; `cmd_ready` high the cycle after the final accept.
- **Backpressure:** `ks_ready` toggled randomly → no word dropped or duplicated; `ks_data` stable while stalled; output sequence matches the no-stall run.
- **Reset mid-operation:** `rst` during WAIT of iteration 4 → all outputs 0; a late `dp_done` is ignored; a new command then produces the correct keystream.
- **Spurious and slow `dp_done`:** a `dp_done` pulse in IDLE/OUT is ignored; a datapath delayed to P+3 cycles → result still correct, with latency increased by 3·D.
- **Timeout (`CHACHA_DP_TIMEOUT_EN` defined):** `dp_done` withheld → `err` pulses once, 16 cycles after `dp_req`; block returns to IDLE; no `ks_valid`.

Source files
------------

// File: rtl/chacha_round_ctrl.sv
// ChaCha block sequencer: builds the input state, loops it through the external double-round
// datapath, adds the feed-forward and streams 16 keystream words per block. Watchdog: CHACHA_DP_TIMEOUT_EN.
module chacha_round_ctrl #(
    parameter int PRO_INTERVAL  = 8,
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [255:0] cmd_key,
    input  logic [95:0]  cmd_nonce,
    input  logic [31:0]  cmd_ctr,
    input  logic [7:0]   cmd_nblk,
    output logic         dp_req,
    output logic [511:0] dp_state_o,
    input  logic [511:0] dp_state_i,
    input  logic         dp_done,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [31:0]  ks_data,
    output logic         ks_last_word,
    output logic         ks_last_blk,
    output logic         err
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ADD, S_OUT} state_e;

    if (DOUBLE_ROUNDS < 1 || DOUBLE_ROUNDS > 15 || PRO_INTERVAL < 1) begin : g_bad_cfg
        $error("chacha_round_ctrl: DOUBLE_ROUNDS must be 1..15 and PRO_INTERVAL >= 1");
    end

    function automatic logic [511:0] build_state(input logic [255:0] key,
                                                 input logic [95:0]  nonce,
                                                 input logic [31:0]  ctr);
        return {nonce, ctr, key, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    endfunction

    state_e         state_q, state_d;
    logic [511:0]   w_q, w_d;
    logic [255:0]   key_q, key_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [31:0]    ctr_q, ctr_d;
    logic [8:0]     rem_q, rem_d;
    logic [3:0]     it_q, it_d;
    logic [3:0]     widx_q, widx_d;

    logic [511:0]   s0;
    logic [3:0]     it_inc;
    logic           rounds_done;
    logic           cmd_fire;
    logic           out_accept;
    logic           blk_end;
    logic           last_blk;
    logic           wd_expired;

    assign s0          = build_state(key_q, nonce_q, ctr_q);
    assign it_inc      = it_q + 4'd1;
    assign rounds_done = (it_inc == 4'(DOUBLE_ROUNDS));
    assign cmd_fire    = cmd_valid && (state_q == S_IDLE) && !rst;
    assign out_accept  = (state_q == S_OUT) && ks_ready;
    assign blk_end     = out_accept && (widx_q == 4'd15);
    assign last_blk    = (rem_q == 9'd1);

`ifdef CHACHA_DP_TIMEOUT_EN
    localparam int WD_W = $clog2(2 * PRO_INTERVAL) + 1;
    logic [WD_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = (state_q == S_WAIT) ? wd_q + WD_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end

    // Expires on the 2*PRO_INTERVAL-th cycle after dp_req; a dp_done in that cycle still wins.
    assign wd_expired = (state_q == S_WAIT) && !dp_done && (wd_q == WD_W'(2 * PRO_INTERVAL - 1));
    assign err        = wd_expired;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_fire) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (dp_done)         state_d = rounds_done ? S_ADD : S_ISSUE;
                else if (wd_expired) state_d = S_IDLE;
            end
            S_ADD:   state_d = S_OUT;
            S_OUT:   if (blk_end) state_d = last_blk ? S_IDLE : S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == S_IDLE) && !rst;
        dp_req       = (state_q == S_ISSUE);
        ks_valid     = (state_q == S_OUT);
        ks_data      = ks_valid ? w_q[{widx_q, 5'd0} +: 32] : 32'd0;
        ks_last_word = ks_valid && (widx_q == 4'd15);
        ks_last_blk  = ks_valid && last_blk;
    end

    assign dp_state_o = w_q;

    // W doubles as the output buffer O once the feed-forward add has been applied.
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        w_d     = w_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        it_d    = it_q;
        widx_d  = widx_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    key_d   = cmd_key;
                    nonce_d = cmd_nonce;
                    ctr_d   = cmd_ctr;
                    rem_d   = (cmd_nblk == 8'd0) ? 9'd256 : {1'b0, cmd_nblk};
                    w_d     = build_state(cmd_key, cmd_nonce, cmd_ctr);
                    it_d    = 4'd0;
                end
            end
            S_WAIT: begin
                if (dp_done) begin
                    w_d  = dp_state_i;
                    it_d = it_inc;
                end
            end
            S_ADD: begin
                for (int n = 0; n < 16; n++) begin
                    w_d[32*n +: 32] = w_q[32*n +: 32] + s0[32*n +: 32];
                end
                widx_d = 4'd0;
            end
            S_OUT: begin
                if (out_accept) widx_d = widx_q + 4'd1;
                if (blk_end && !last_blk) begin
                    rem_d = rem_q - 9'd1;
                    ctr_d = ctr_q + 32'd1;
                    w_d   = build_state(key_q, nonce_q, ctr_q + 32'd1);
                    it_d  = 4'd0;
                end
            end
            default: ;
        endcase
    end

    // W is reset because it drives dp_state_o directly, which must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q    <= '0;
            rem_q  <= '0;
            it_q   <= '0;
            widx_q <= '0;
        end else begin
            w_q    <= w_d;
            rem_q  <= rem_d;
            it_q   <= it_d;
            widx_q <= widx_d;
        end
    end

    // NOTE: command registers carry no reset; they are only read after a handshake has loaded them.
    always_ff @(posedge clk) begin
        key_q   <= key_d;
        nonce_q <= nonce_d;
        ctr_q   <= ctr_d;
    end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Bench for chacha_round_ctrl: behavioural double-round datapath, ChaCha block reference model,
// table of command vectors plus hand-written reset / spurious-done / timeout sequences.
module tb_chacha_round_ctrl;

    localparam int P = 8;
    localparam int D = 10;

    typedef struct {
        string        name;
        logic [255:0] key;
        logic [95:0]  nonce;
        logic [31:0]  ctr;
        logic [7:0]   nblk;
        int           lat;
        bit           rnd;
        bit           spur;
        bit           chk_w;
        logic [31:0]  w0;
        logic [31:0]  w15;
        int           first;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] cmd_key;
    logic [95:0]  cmd_nonce;
    logic [31:0]  cmd_ctr;
    logic [7:0]   cmd_nblk;
    logic         dp_req;
    logic [511:0] dp_state_o;
    logic [511:0] dp_state_i;
    logic         dp_done;
    logic         ks_valid;
    logic         ks_ready;
    logic [31:0]  ks_data;
    logic         ks_last_word;
    logic         ks_last_blk;
    logic         err;

    chacha_round_ctrl #(.PRO_INTERVAL(P), .DOUBLE_ROUNDS(D)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_nonce(cmd_nonce), .cmd_ctr(cmd_ctr), .cmd_nblk(cmd_nblk),
        .dp_req(dp_req), .dp_state_o(dp_state_o), .dp_state_i(dp_state_i), .dp_done(dp_done),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .ks_last_word(ks_last_word), .ks_last_blk(ks_last_blk), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ChaCha reference ----------------
    function automatic logic [127:0] quarter(input logic [31:0] a_i, b_i, c_i, d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] double_round(input logic [511:0] s);
        logic [31:0]  x [16];
        logic [127:0] t;
        int           q [8][4];
        logic [511:0] r;
        q = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
              '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int k = 0; k < 8; k++) begin
            t = quarter(x[q[k][0]], x[q[k][1]], x[q[k][2]], x[q[k][3]]);
            x[q[k][0]] = t[31:0];
            x[q[k][1]] = t[63:32];
            x[q[k][2]] = t[95:64];
            x[q[k][3]] = t[127:96];
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
        return r;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] nonce,
                                               input logic [31:0] ctr);
        logic [31:0]  init [16];
        logic [511:0] x, r;
        init[0] = 32'h61707865; init[1] = 32'h3320646e;
        init[2] = 32'h79622d32; init[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) init[4+i] = key[32*i +: 32];
        init[12] = ctr;
        for (int j = 0; j < 3; j++) init[13+j] = nonce[32*j +: 32];
        for (int n = 0; n < 16; n++) x[32*n +: 32] = init[n];
        repeat (D) x = double_round(x);
        for (int n = 0; n < 16; n++) r[32*n +: 32] = x[32*n +: 32] + init[n];
        return r;
    endfunction

    // ---------------- datapath model, ready driver, monitor ----------------
    int           cyc = 0;
    int           dp_cnt = 0;
    int           dp_lat = P;
    bit           dp_mute = 0;
    bit           spur_issue = 0;
    bit           spur_out = 0;
    bit           spur_now = 0;
    bit           rand_ready = 0;
    logic [511:0] dp_res;

    logic [33:0]  got_q [$];
    int           acc_cyc [$];
    int           req_cyc [$];
    int           first_valid = -1;
    int           stall_bad = 0;
    int           err_cnt = 0;
    int           err_cyc = -1;
    bit           stalled = 0;
    logic [33:0]  prev_out;

    initial begin
        dp_done    = 1'b0;
        dp_state_i = '0;
        ks_ready   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            dp_done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0 && !dp_mute) begin
                    dp_done    = 1'b1;
                    dp_state_i = dp_res;
                end
            end
            if (dp_req) begin
                req_cyc.push_back(cyc);
                dp_res = double_round(dp_state_o);
                dp_cnt = dp_lat;
                if (spur_issue) begin
                    dp_done    = 1'b1;
                    dp_state_i = {16{$urandom}};
                end
            end else if ((spur_out && ks_valid && $urandom_range(0, 3) == 0) || spur_now) begin
                dp_done    = 1'b1;
                dp_state_i = {16{$urandom}};
                spur_now   = 0;
            end
            ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (ks_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled && {ks_data, ks_last_word, ks_last_blk} !== prev_out) stall_bad++;
                prev_out = {ks_data, ks_last_word, ks_last_blk};
                stalled  = !ks_ready;
                if (ks_ready) begin
                    got_q.push_back({ks_data, ks_last_word, ks_last_blk});
                    acc_cyc.push_back(cyc);
                end
            end else begin
                stalled = 0;
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    // ---------------- command tasks ----------------
    task automatic start_cmd(input vec_t v, output int c0);
        int waited = 0;
        dp_lat     = v.lat;
        rand_ready = v.rnd;
        spur_issue = v.spur;
        spur_out   = v.spur;
        got_q.delete();
        acc_cyc.delete();
        req_cyc.delete();
        first_valid = -1;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check({v.name, " cmd_ready before cmd"}, cmd_ready, 1);
        cmd_key   = v.key;
        cmd_nonce = v.nonce;
        cmd_ctr   = v.ctr;
        cmd_nblk  = v.nblk;
        cmd_valid = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check({v.name, " dp_req at cycle 1"}, dp_req, 1);
    endtask

    task automatic finish_cmd(input vec_t v, input int c0);
        logic [33:0] exp_q [$];
        logic [511:0] blk;
        int nb, n_exp, budget, nbad;
        nb = (v.nblk == 8'd0) ? 256 : int'(v.nblk);
        for (int b = 0; b < nb; b++) begin
            blk = ref_block(v.key, v.nonce, v.ctr + 32'(b));
            for (int w = 0; w < 16; w++)
                exp_q.push_back({blk[32*w +: 32], w == 15, b == nb - 1});
        end
        n_exp  = nb * 16;
        budget = nb * (D * (v.lat + 1) + 4 + 16 * (v.rnd ? 8 : 2)) + 100;
        while (got_q.size() < n_exp && cyc - c0 < budget) begin
            @(posedge clk); #3;
        end
        check({v.name, " word count"}, got_q.size(), n_exp);
        nbad = 0;
        for (int i = 0; i < n_exp && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nbad++;
        check({v.name, " mismatched words"}, nbad, 0);
        check({v.name, " first ks_valid cycle"}, first_valid - c0, v.first);
        check({v.name, " unstable while stalled"}, stall_bad, 0);
        if (v.chk_w && got_q.size() >= 16) begin
            check({v.name, " word0"}, got_q[0][33:2], v.w0);
            check({v.name, " word15"}, got_q[15][33:2], v.w15);
            check({v.name, " word15 flags"}, got_q[15][1:0], 2'b11);
        end
        if (nb >= 2 && acc_cyc.size() >= 16 && req_cyc.size() > D)
            check({v.name, " next dp_req after word15"}, req_cyc[D], acc_cyc[15] + 1);
        check({v.name, " cmd_ready low at final accept"}, cmd_ready, 0);
        @(posedge clk); #1;
        check({v.name, " cmd_ready after final accept"}, cmd_ready, 1);
        check({v.name, " ks_valid after final accept"}, ks_valid, 0);
    endtask

    task automatic run_cmd(input vec_t v);
        int c0;
        start_cmd(v, c0);
        finish_cmd(v, c0);
    endtask

    // ---------------- main ----------------
    vec_t         vecs [7];
    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    int           c0;
    int           waited;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_key = '0; cmd_nonce = '0; cmd_ctr = '0; cmd_nblk = '0;

        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = 96'h00000000_4a000000_09000000;
        vecs[0] = '{"rfc", rfc_key, rfc_nonce, 32'd1, 8'd1, P, 0, 0, 1,
                    32'he4e7f110, 32'h4e3c50a2, 92};
        vecs[1] = '{"wrap", {8{$urandom}}, {3{$urandom}}, 32'hFFFFFFFE, 8'd3, P, 0, 0, 0,
                    32'd0, 32'd0, D * (P + 1) + 2};
        vecs[2] = vecs[1];
        vecs[2].name = "wrap_bp";
        vecs[2].rnd  = 1;
        vecs[3] = '{"slow_spur", rfc_key, rfc_nonce, 32'd1, 8'd1, P + 3, 0, 1, 1,
                    32'he4e7f110, 32'h4e3c50a2, 122};
        vecs[4] = '{"rand_lat", {8{$urandom}}, {3{$urandom}}, $urandom, 8'd2, 0, 1, 1, 0,
                    32'd0, 32'd0, 0};
        vecs[4].lat   = $urandom_range(1, 12);
        vecs[4].first = D * (vecs[4].lat + 1) + 2;
        vecs[5] = '{"nblk256", {8{$urandom}}, {3{$urandom}}, $urandom, 8'd0, P, 0, 0, 0,
                    32'd0, 32'd0, D * (P + 1) + 2};
        vecs[6] = '{"ctr_max_bp", {8{$urandom}}, {3{$urandom}}, 32'hFFFFFFFF, 8'd1, P, 1, 0, 0,
                    32'd0, 32'd0, D * (P + 1) + 2};

        // reset state
        @(posedge clk); #1;
        check("cmd_ready during rst", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst dp_req", dp_req, 0);
        check("rst dp_state_o", |dp_state_o, 0);
        check("rst ks_valid", ks_valid, 0);
        check("rst ks_data", ks_data, 0);
        check("rst last flags", {ks_last_word, ks_last_blk}, 0);
        check("rst err", err, 0);
        rst = 1'b0;
        #1;
        check("cmd_ready after rst", cmd_ready, 1);

        // spurious dp_done in IDLE
        @(posedge clk); #1;
        spur_now = 1;
        repeat (4) @(posedge clk);
        #3;
        check("idle spur: cmd_ready", cmd_ready, 1);
        check("idle spur: no dp_req", req_cyc.size(), 0);
        check("idle spur: no ks_valid", first_valid, -1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // reset while waiting on iteration 4, then a late dp_done in IDLE
        start_cmd(vecs[0], c0);
        waited = 0;
        while (req_cyc.size() < 5 && waited < 200) begin
            @(posedge clk); #3;
            waited++;
        end
        check("mid rst: reached iteration 4", req_cyc.size(), 5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid rst: cmd_ready", cmd_ready, 0);
        check("mid rst: dp_req", dp_req, 0);
        check("mid rst: dp_state_o", |dp_state_o, 0);
        check("mid rst: ks outputs", {ks_valid, ks_data, ks_last_word, ks_last_blk}, 0);
        rst = 1'b0;
        #1;
        check("mid rst: cmd_ready released", cmd_ready, 1);
        repeat (P + 2) @(posedge clk);
        #3;
        check("late done: no dp_req", req_cyc.size(), 5);
        check("late done: no ks_valid", first_valid, -1);
        check("late done: still idle", cmd_ready, 1);
        @(posedge clk); #1;
        run_cmd(vecs[0]);

`ifdef CHACHA_DP_TIMEOUT_EN
        err_cnt = 0;
        dp_mute = 1;
        start_cmd(vecs[1], c0);
        waited = 0;
        while (err_cnt == 0 && waited < 4 * P + 10) begin
            @(posedge clk); #3;
            waited++;
        end
        repeat (3) @(posedge clk);
        #3;
        check("timeout: err pulses", err_cnt, 1);
        if (req_cyc.size() > 0) check("timeout: err delay", err_cyc - req_cyc[0], 2 * P);
        check("timeout: back to idle", cmd_ready, 1);
        check("timeout: no ks_valid", first_valid, -1);
        dp_mute = 0;
        @(posedge clk); #1;
`else
        check("err never asserted", err_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
